// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter request front end: client count and index type.
package arb_pkg;

  localparam int NUM_REQUESTERS = 4;
  localparam int DEFAULT_DEPTH  = 3;
  localparam int CLIENT_IDX_W   = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  typedef logic [CLIENT_IDX_W-1:0] client_idx_t;

endpackage

// File: rtl/arb_req_client.sv
// Per-client pending-request counter with pass-over tracking and a sticky starvation flag.
module arb_req_client
  import arb_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int PASS_MAX = NUM_REQUESTERS
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic pass_i,
  output logic ready_o,
  output logic req_o,
  output logic starve_o
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PASS_W = $clog2(PASS_MAX + 1);

  logic [CNT_W-1:0]  pend_cnt_reg, pend_cnt_next;
  logic [PASS_W-1:0] pass_cnt_reg, pass_cnt_next;
  logic              starve_reg, starve_next;
  logic              accept;

  assign ready_o  = (pend_cnt_reg < CNT_W'(DEPTH));
  assign req_o    = (pend_cnt_reg != '0);
  assign starve_o = starve_reg;
  assign accept   = push_i & ready_o;

  always_comb begin
    pend_cnt_next = pend_cnt_reg;
    pass_cnt_next = pass_cnt_reg;
    starve_next   = starve_reg;

    if (accept && !pop_i) begin
      pend_cnt_next = pend_cnt_reg + CNT_W'(1);
    end else if (!accept && pop_i) begin
      pend_cnt_next = pend_cnt_reg - CNT_W'(1);
    end

    // Being served or going idle resets the fairness window.
    if (pop_i || (pend_cnt_next == '0)) begin
      pass_cnt_next = '0;
    end else if (pass_i && req_o) begin
      if (pass_cnt_reg >= PASS_W'(PASS_MAX - 1)) begin
        starve_next = 1'b1;
      end
      if (pass_cnt_reg < PASS_W'(PASS_MAX)) begin
        pass_cnt_next = pass_cnt_reg + PASS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_cnt_reg <= '0;
      pass_cnt_reg <= '0;
      starve_reg   <= 1'b0;
    end else begin
      pend_cnt_reg <= pend_cnt_next;
      pass_cnt_reg <= pass_cnt_next;
      starve_reg   <= starve_next;
    end
  end

endmodule

// File: rtl/arb_req_front.sv
// Request front end for a round-robin arbiter: per-client queues, grant decode, yumi and protocol check.
module arb_req_front #(
  parameter int NUM_REQUESTERS = arb_pkg::NUM_REQUESTERS,
  parameter int DEPTH          = arb_pkg::DEFAULT_DEPTH
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NUM_REQUESTERS-1:0]         push_i,
  output logic [NUM_REQUESTERS-1:0]         ready_o,
  output logic [NUM_REQUESTERS-1:0]         reqs_o,
  input  logic [NUM_REQUESTERS-1:0]         grants_i,
  output logic                              yumi_o,
  output logic                              sink_v_o,
  output logic [$clog2(NUM_REQUESTERS)-1:0] sink_id_o,
  input  logic                              sink_ready_i,
  output logic [NUM_REQUESTERS-1:0]         starve_o,
  output logic                              error_o
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0] reqs;
  logic [NUM_REQUESTERS-1:0] valid_grant;
  logic [NUM_REQUESTERS-1:0] pop_vec;
  logic [IDX_W-1:0]          sink_id;
  logic                      grant_multi, grant_orphan;
  logic                      error_reg, error_next;

  assign valid_grant = grants_i & reqs;
  assign sink_v_o    = |valid_grant;
  assign yumi_o      = sink_v_o & sink_ready_i;
  assign sink_id_o   = sink_id;
  assign reqs_o      = reqs;

  // Lowest set bit wins so a malformed multi-bit grant still yields one well-defined pop.
  always_comb begin
    sink_id = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (valid_grant[i]) begin
        sink_id = IDX_W'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_client
      assign pop_vec[gi] = yumi_o && (sink_id == IDX_W'(gi));

      arb_req_client #(
        .DEPTH    (DEPTH),
        .PASS_MAX (NUM_REQUESTERS)
      ) u_client (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .push_i   (push_i[gi]),
        .pop_i    (pop_vec[gi]),
        .pass_i   (yumi_o && !pop_vec[gi]),
        .ready_o  (ready_o[gi]),
        .req_o    (reqs[gi]),
        .starve_o (starve_o[gi])
      );
    end
  endgenerate

  assign grant_multi  = |(grants_i & (grants_i - NUM_REQUESTERS'(1)));
  assign grant_orphan = |(grants_i & ~reqs);
  assign error_next   = error_reg | grant_multi | grant_orphan;
  assign error_o      = error_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_reg <= 1'b0;
    end else begin
      error_reg <= error_next;
    end
  end

endmodule

// File: tb/tb_arb_req_front.sv
// Self-checking bench for arb_req_front: vector table, hand sequences and a yumi-id scoreboard.
module tb_arb_req_front;

  localparam logic [3:0] F = 4'b1111;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] push_i = '0;
  logic [3:0] ready_o;
  logic [3:0] reqs_o;
  logic [3:0] grants_i = '0;
  logic       yumi_o;
  logic       sink_v_o;
  logic [1:0] sink_id_o;
  logic       sink_ready_i = 1'b0;
  logic [3:0] starve_o;
  logic       error_o;

  arb_req_front #(.NUM_REQUESTERS(4), .DEPTH(3)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .push_i       (push_i),
    .ready_o      (ready_o),
    .reqs_o       (reqs_o),
    .grants_i     (grants_i),
    .yumi_o       (yumi_o),
    .sink_v_o     (sink_v_o),
    .sink_id_o    (sink_id_o),
    .sink_ready_i (sink_ready_i),
    .starve_o     (starve_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] push;
    logic [3:0] grants;
    logic       sready;
    logic [3:0] exp_ready;
    logic [3:0] exp_reqs;
    logic       exp_v;
    logic       exp_yumi;
    logic [1:0] exp_id;
    logic [3:0] exp_starve;
    logic       exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  arb_pkg::client_idx_t exp_q[$];
  vec_t tbl[16];

  function automatic vec_t mk(input logic [3:0] push, input logic [3:0] grants, input logic sready,
                              input logic [3:0] rdy, input logic [3:0] reqs, input logic v,
                              input logic yumi, input logic [1:0] id, input logic [3:0] starve,
                              input logic err);
    vec_t r;
    r.push = push; r.grants = grants; r.sready = sready;
    r.exp_ready = rdy; r.exp_reqs = reqs; r.exp_v = v; r.exp_yumi = yumi;
    r.exp_id = id; r.exp_starve = starve; r.exp_err = err;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, check pre-edge outputs, then advance to the next falling edge.
  task automatic step(input vec_t v, input string tag);
    arb_pkg::client_idx_t want;
    push_i       = v.push;
    grants_i     = v.grants;
    sink_ready_i = v.sready;
    #1;
    $display("[%0t] %s push=%b grants=%b srdy=%b -> ready=%b reqs=%b v=%b yumi=%b id=%0d starve=%b err=%b",
             $time, tag, push_i, grants_i, sink_ready_i, ready_o, reqs_o, sink_v_o, yumi_o,
             sink_id_o, starve_o, error_o);
    check({tag, ".ready"},  ready_o,  v.exp_ready);
    check({tag, ".reqs"},   reqs_o,   v.exp_reqs);
    check({tag, ".sink_v"}, sink_v_o, v.exp_v);
    check({tag, ".yumi"},   yumi_o,   v.exp_yumi);
    check({tag, ".starve"}, starve_o, v.exp_starve);
    check({tag, ".error"},  error_o,  v.exp_err);
    if (v.exp_yumi) exp_q.push_back(v.exp_id);
    if (yumi_o) begin
      if (exp_q.size() == 0) begin
        check({tag, ".sb_unexpected_yumi"}, 1, 0);
      end else begin
        want = exp_q.pop_front();
        check({tag, ".sb_id"}, sink_id_o, want);
      end
    end
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    push_i = '0; grants_i = '0; sink_ready_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    // Single push/serve, then fill-to-depth with stall, drain, and push+pop in one cycle.
    tbl[0]  = mk(4'b0100, 4'b0000, 1, F,       4'b0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0000, 4'b0100, 1, F,       4'b0100, 1, 1, 2, 0, 0);
    tbl[2]  = mk(4'b0000, 4'b0000, 1, F,       4'b0000, 0, 0, 0, 0, 0);
    tbl[3]  = mk(4'b0001, 4'b0000, 0, F,       4'b0000, 0, 0, 0, 0, 0);
    tbl[4]  = mk(4'b0001, 4'b0001, 0, F,       4'b0001, 1, 0, 0, 0, 0);
    tbl[5]  = mk(4'b0001, 4'b0001, 0, F,       4'b0001, 1, 0, 0, 0, 0);
    tbl[6]  = mk(4'b0001, 4'b0001, 0, 4'b1110, 4'b0001, 1, 0, 0, 0, 0);
    tbl[7]  = mk(4'b0000, 4'b0001, 0, 4'b1110, 4'b0001, 1, 0, 0, 0, 0);
    tbl[8]  = mk(4'b0000, 4'b0001, 1, 4'b1110, 4'b0001, 1, 1, 0, 0, 0);
    tbl[9]  = mk(4'b0000, 4'b0001, 1, F,       4'b0001, 1, 1, 0, 0, 0);
    tbl[10] = mk(4'b0000, 4'b0001, 1, F,       4'b0001, 1, 1, 0, 0, 0);
    tbl[11] = mk(4'b0000, 4'b0000, 1, F,       4'b0000, 0, 0, 0, 0, 0);
    tbl[12] = mk(4'b0010, 4'b0000, 1, F,       4'b0000, 0, 0, 0, 0, 0);
    tbl[13] = mk(4'b0010, 4'b0010, 1, F,       4'b0010, 1, 1, 1, 0, 0);
    tbl[14] = mk(4'b0000, 4'b0010, 1, F,       4'b0010, 1, 1, 1, 0, 0);
    tbl[15] = mk(4'b0000, 4'b0000, 1, F,       4'b0000, 0, 0, 0, 0, 0);

    // Outputs while held in reset
    #1;
    check("rst.ready",  ready_o,  F);
    check("rst.reqs",   reqs_o,   0);
    check("rst.sink_v", sink_v_o, 0);
    check("rst.yumi",   yumi_o,   0);
    check("rst.starve", starve_o, 0);
    check("rst.error",  error_o,  0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    // All four clients served on consecutive cycles by a round-robin grant
    step(mk(4'b1111, 4'b0000, 1, F, 4'b0000, 0, 0, 0, 0, 0), "rr_push");
    for (int k = 0; k < 4; k++) begin
      logic [3:0] g;
      logic [3:0] r;
      g = 4'b0001 << k;
      r = F << k;
      step(mk(4'b0000, g, 1, F, r, 1, 1, 2'(k), 0, 0), $sformatf("rr%0d", k));
    end
    step(mk(4'b0000, 4'b0000, 1, F, 4'b0000, 0, 0, 0, 0, 0), "rr_idle");

    // Client 1 passed over four times while client 0 is always granted
    step(mk(4'b0011, 4'b0000, 1, F, 4'b0000, 0, 0, 0, 0, 0), "stv_push");
    for (int k = 0; k < 4; k++) begin
      step(mk(4'b0001, 4'b0001, 1, F, 4'b0011, 1, 1, 0, 0, 0), $sformatf("stv%0d", k));
    end
    step(mk(4'b0000, 4'b0010, 1, F, 4'b0011, 1, 1, 1, 4'b0010, 0), "stv_pop1");
    step(mk(4'b0000, 4'b0001, 1, F, 4'b0001, 1, 1, 0, 4'b0010, 0), "stv_pop0");
    step(mk(4'b0000, 4'b0000, 1, F, 4'b0000, 0, 0, 0, 4'b0010, 0), "stv_hold");

    // Multi-bit grant raises a sticky error
    do_reset();
    step(mk(4'b0011, 4'b0000, 0, F, 4'b0000, 0, 0, 0, 0, 0), "err_push");
    step(mk(4'b0000, 4'b0011, 0, F, 4'b0011, 1, 0, 0, 0, 0), "err_multi");
    step(mk(4'b0000, 4'b0000, 0, F, 4'b0011, 0, 0, 0, 0, 1), "err_set");
    step(mk(4'b0000, 4'b0000, 0, F, 4'b0011, 0, 0, 0, 0, 1), "err_hold");

    // Grant to an idle client, then asynchronous reset mid-cycle with work pending
    do_reset();
    step(mk(4'b0111, 4'b0000, 0, F, 4'b0000, 0, 0, 0, 0, 0), "ar_fill");
    step(mk(4'b0000, 4'b1000, 0, F, 4'b0111, 0, 0, 0, 0, 0), "ar_orphan");
    push_i = '0; grants_i = 4'b0001; sink_ready_i = 1'b1;
    #1;
    check("ar.pre_error", error_o, 1);
    check("ar.pre_yumi",  yumi_o,  1);
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    $display("[%0t] async_reset -> ready=%b reqs=%b v=%b yumi=%b starve=%b err=%b",
             $time, ready_o, reqs_o, sink_v_o, yumi_o, starve_o, error_o);
    check("ar.ready",  ready_o,  F);
    check("ar.reqs",   reqs_o,   0);
    check("ar.sink_v", sink_v_o, 0);
    check("ar.yumi",   yumi_o,   0);
    check("ar.starve", starve_o, 0);
    check("ar.error",  error_o,  0);
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(mk(4'b0000, 4'b0000, 1, F, 4'b0000, 0, 0, 0, 0, 0), $sformatf("ar_post%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
